// File: rtl/delay_window.sv
// delay_window: line-buffered HEIGHT_NB x WIDTH_NB neighbourhood generator.
// One circular line RAM holds the previous HEIGHT_NB-1 lines per column; a
// per-row shift register forms the column window. Two-stage pipeline with
// ready/valid back-pressure, border suppression and a frame-last flag.

// One window row: WIDTH_NB-deep pixel shift register, tap 0 is the newest column.
module delay_window_row #(
    parameter int WIDTH_NB = 3,
    parameter int PIX      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PIX-1:0]          din,
    output logic [WIDTH_NB*PIX-1:0] dout
);
    logic [WIDTH_NB-1:0][PIX-1:0] taps;

    // Shift a new column in at tap 0; the oldest tap drops out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps <= '0;
        end else if (en) begin
            taps[0] <= din;
            for (int w = 1; w < WIDTH_NB; w++) taps[w] <= taps[w-1];
        end
    end

    assign dout = taps;
endmodule

module delay_window #(
    parameter int HEIGHT_NB  = 3,
    parameter int WIDTH_NB   = 3,
    parameter int CHANNELS   = 1,
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 16,
    parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [MEM_AWIDTH-1:0]                           cfg_line,
    input  logic [MEM_AWIDTH-1:0]                           cfg_lines,
    input  logic                                            cfg_set,
    input  logic [IMG_WIDTH*CHANNELS-1:0]                   up_data,
    input  logic                                            up_val,
    output logic                                            up_rdy,
    output logic [IMG_WIDTH*CHANNELS*HEIGHT_NB*WIDTH_NB-1:0] dn_data,
    output logic                                            dn_val,
    input  logic                                            dn_rdy,
    output logic                                            dn_last
);
    localparam int PIX    = IMG_WIDTH * CHANNELS;
    localparam int STAGES = 2;
    localparam int RAW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [MEM_AWIDTH:0]   DEPTH_L  = (MEM_AWIDTH+1)'(MEM_DEPTH);
    localparam logic [MEM_AWIDTH-1:0] ONE      = MEM_AWIDTH'(1);
    localparam logic [MEM_AWIDTH-1:0] W_MIN    = MEM_AWIDTH'(WIDTH_NB);
    localparam logic [MEM_AWIDTH-1:0] H_MIN    = MEM_AWIDTH'(HEIGHT_NB);
    localparam logic [MEM_AWIDTH-1:0] ROW_WIN  = MEM_AWIDTH'(HEIGHT_NB - 1);
    localparam logic [MEM_AWIDTH-1:0] COL_WIN  = MEM_AWIDTH'(WIDTH_NB - 1);
    localparam logic [MEM_AWIDTH-1:0] ROW_PRE  = MEM_AWIDTH'(HEIGHT_NB - 2);

    logic [1:0]            state;
    logic [MEM_AWIDTH-1:0] line_q, lines_q, col, row;
    logic                  adv, accept, cfg_ok, col_wrap, row_wrap, shift_en;
    logic [STAGES:1]       vld_pipe;
    logic [PIX-1:0]        s1_data;
    logic                  s1_win, s1_last;
    logic [RAW-1:0]        ra;

    // Line RAM entry: slot k holds the pixel from k+1 lines ago at this column.
    logic [HEIGHT_NB-2:0][PIX-1:0] mem [MEM_DEPTH];
    logic [HEIGHT_NB-2:0][PIX-1:0] ram_cur, ram_wr, rd_q;
    logic [HEIGHT_NB-1:0][PIX-1:0]          new_col;
    logic [HEIGHT_NB-1:0][WIDTH_NB*PIX-1:0] win;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign adv      = ~vld_pipe[2] | dn_rdy;
    assign up_rdy   = adv & (state != S_IDLE) & ~cfg_set;
    assign accept   = up_val & up_rdy;
    assign dn_val   = vld_pipe[2];
    assign dn_data  = win;
    assign col_wrap = (col == line_q - ONE);
    assign row_wrap = (row == lines_q - ONE);
    assign cfg_ok   = ({1'b0, cfg_line} <= DEPTH_L) & (cfg_line >= W_MIN) & (cfg_lines >= H_MIN);
    assign ra       = col[RAW-1:0];
    assign shift_en = adv & vld_pipe[1] & ~cfg_set;

    // Frame control: config latch, column/row counters, fill/run state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            line_q  <= '0;
            lines_q <= '0;
            col     <= '0;
            row     <= '0;
        end else if (cfg_set) begin
            col <= '0;
            row <= '0;
            if (cfg_ok) begin
                line_q  <= cfg_line;
                lines_q <= cfg_lines;
                state   <= S_FILL;
            end else begin
                state <= S_IDLE;
            end
        end else if (accept) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row   <= '0;
                    state <= S_FILL;
                end else begin
                    row <= row + ONE;
                    if (row >= ROW_PRE) state <= S_RUN;
                end
            end else begin
                col <= col + ONE;
            end
        end
    end

    // Stage 1 capture plus valid shift; border windows are masked going into stage 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_win   <= 1'b0;
            s1_last  <= 1'b0;
            dn_last  <= 1'b0;
        end else if (cfg_set) begin
            vld_pipe <= '0;
            dn_last  <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[1] & s1_win, accept};
            dn_last  <= vld_pipe[1] & s1_last;
            if (accept) begin
                s1_data <= up_data;
                s1_win  <= (row >= ROW_WIN) & (col >= COL_WIN);
                s1_last <= row_wrap & col_wrap;
            end
        end
    end

    // Column history rotates by one line: new pixel into slot 0, slots age by one.
    always_comb begin
        ram_cur    = mem[ra];
        ram_wr     = ram_cur;
        ram_wr[0]  = up_data;
        for (int k = 1; k < HEIGHT_NB - 1; k++) ram_wr[k] = ram_cur[k-1];
    end

    // Read-old-data line RAM: the same edge reads history and writes the rotated entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ra] <= ram_wr;
            rd_q    <= ram_cur;
        end
    end

    // New column: h=0 is the incoming pixel, h>=1 are the older lines.
    always_comb begin
        new_col[0] = s1_data;
        for (int k = 1; k < HEIGHT_NB; k++) new_col[k] = rd_q[k-1];
    end

    for (genvar h = 0; h < HEIGHT_NB; h++) begin : g_row
        delay_window_row #(
            .WIDTH_NB (WIDTH_NB),
            .PIX      (PIX)
        ) u_row (
            .clk  (clk),
            .rst  (rst),
            .en   (shift_en),
            .din  (new_col[h]),
            .dout (win[h])
        );
    end
endmodule

// File: tb/tb_delay_window.sv
// Bench for delay_window: frame-level reference model feeds a window scoreboard;
// an independent monitor pops and compares each window the DUT hands over.
module tb_delay_window;
    localparam int H = 3, W = 3, C = 1, IW = 8, AW = 8, DEPTH = 16;
    localparam int DW = IW * C * H * W;

    logic          clk = 1'b0, rst = 1'b0;
    logic [AW-1:0] cfg_line = '0, cfg_lines = '0;
    logic          cfg_set = 1'b0;
    logic [IW-1:0] up_data = '0;
    logic          up_val = 1'b0, up_rdy;
    logic [DW-1:0] dn_data;
    logic          dn_val, dn_last;
    logic          dn_rdy = 1'b1;

    delay_window #(
        .HEIGHT_NB(H), .WIDTH_NB(W), .CHANNELS(C), .IMG_WIDTH(IW),
        .MEM_AWIDTH(AW), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_line(cfg_line), .cfg_lines(cfg_lines),
        .cfg_set(cfg_set), .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy), .dn_last(dn_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            errors = 0, checks = 0, cyc = 0, win_cnt = 0, rdy_mode = 0;
    bit            lat_chk = 1'b0;
    int            m_row = 0, m_col = 0, g_line = 5, g_lines = 4;
    logic [IW-1:0] img [16][16];
    logic          held = 1'b0;
    logic [DW-1:0] held_d = '0;

    always @(posedge clk) cyc++;

    // dn_rdy pattern: 0 always ready, 1 random, 2 forced stall
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dn_rdy = 1'b1;
            1:       dn_rdy = 1'($urandom_range(1));
            default: dn_rdy = 1'b0;
        endcase
    end

    // Reference model: store each accepted pixel in a frame image; a complete
    // neighbourhood is read straight out of that image.
    function automatic void model_accept(input logic [IW-1:0] p);
        exp_t e;
        img[m_row][m_col] = p;
        if (m_row >= H - 1 && m_col >= W - 1) begin
            e.d = '0;
            for (int h = 0; h < H; h++)
                for (int w = 0; w < W; w++)
                    e.d[(h*W + w)*IW +: IW] = img[m_row-h][m_col-w];
            e.last = (m_row == g_lines - 1) && (m_col == g_line - 1);
            e.cyc  = cyc;
            q.push_back(e);
        end
        if (m_col == g_line - 1) begin
            m_col = 0;
            m_row = (m_row == g_lines - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endfunction

    always @(negedge clk) if (rst && up_val && up_rdy) model_accept(up_data);

    // Output monitor: stall stability, back-pressure, and scoreboard compare.
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!dn_val || dn_data !== held_d) begin
                    errors++;
                    $display("FAIL stall_hold: dn_val=%0b dn_data=%h, required dn_val=1 dn_data=%h",
                             dn_val, dn_data, held_d);
                end
            end
            if (dn_val && !dn_rdy) begin
                checks++;
                if (up_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_up_rdy: up_rdy=%0b, required 0", up_rdy);
                end
            end
            held   = dn_val && !dn_rdy;
            held_d = dn_data;
            if (dn_val && dn_rdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_window: dn_data=%h dn_last=%0b, none pending", dn_data, dn_last);
                end else begin
                    mon_e = q.pop_front();
                    win_cnt++;
                    if (dn_data !== mon_e.d || dn_last !== mon_e.last) begin
                        errors++;
                        $display("FAIL window: got %h last=%0b, required %h last=%0b",
                                 dn_data, dn_last, mon_e.d, mon_e.last);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - mon_e.cyc != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d clk, required 2", cyc - mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send_pix(input logic [IW-1:0] p);
        bit done = 1'b0;
        int g = 0;
        up_data = p;
        up_val  = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = up_rdy;
            tick();
            g++;
            if (!done && g >= 2000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: pixel %h not accepted in %0d clk", p, g);
                done = 1'b1;
            end
        end
        up_val = 1'b0;
    endtask

    task automatic send_frame(input int duty, input bit rnd);
        for (int r = 0; r < g_lines; r++)
            for (int c = 0; c < g_line; c++) begin
                while (duty < 100 && int'($urandom_range(99)) >= duty) begin
                    up_val  = 1'b0;
                    up_data = IW'($urandom);
                    tick();
                end
                send_pix(rnd ? IW'($urandom) : IW'(r*16 + c));
            end
    endtask

    task automatic drain(input int n_win);
        int g = 0;
        while ((q.size() != 0 || dn_val) && g < 500) begin
            tick();
            g++;
        end
        chk("pending_windows", q.size(), 0);
        chk("window_count", win_cnt, n_win);
        win_cnt = 0;
    endtask

    task automatic do_cfg(input int line, input int lines, input bit ok);
        cfg_line  = AW'(line);
        cfg_lines = AW'(lines);
        cfg_set   = 1'b1;
        up_val    = 1'b1;
        up_data   = 8'hAA;
        @(negedge clk);
        chk("cfg_set_up_rdy", up_rdy, 0);
        tick();
        cfg_set = 1'b0;
        up_val  = 1'b0;
        m_row   = 0;
        m_col   = 0;
        win_cnt = 0;
        if (ok) begin
            g_line  = line;
            g_lines = lines;
        end else begin
            up_val = 1'b1;
            repeat (4) begin
                @(negedge clk);
                chk("idle_up_rdy", up_rdy, 0);
                chk("idle_dn_val", dn_val, 0);
                tick();
            end
            up_val = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("reset_up_rdy", up_rdy, 0);
        chk("reset_dn_val", dn_val, 0);
        chk("reset_dn_last", dn_last, 0);
        chk("reset_dn_data", dn_data, 0);
        rst = 1'b1;
        up_val = 1'b1;
        tick();
        @(negedge clk);
        chk("unconfigured_up_rdy", up_rdy, 0);
        tick();
        up_val = 1'b0;

        // 1: single frame, continuous stream, latency tracked
        do_cfg(5, 4, 1'b1);
        lat_chk = 1'b1;
        send_frame(100, 1'b0);
        drain(6);

        // 2: forced 4-clk stall in the middle of the windowed region
        lat_chk = 1'b0;
        fork
            send_frame(100, 1'b0);
            begin
                repeat (15) @(posedge clk);
                rdy_mode = 2;
                repeat (4) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain(6);

        // 3: two back-to-back frames without reconfiguration
        lat_chk = 1'b1;
        send_frame(100, 1'b0);
        send_frame(100, 1'b0);
        drain(12);

        // 4: rejected configurations, then recovery
        lat_chk = 1'b0;
        do_cfg(2, 4, 1'b0);
        do_cfg(DEPTH + 1, 4, 1'b0);
        do_cfg(5, 2, 1'b0);
        do_cfg(5, 4, 1'b1);
        send_frame(100, 1'b0);
        drain(6);

        // 5: asynchronous reset mid-frame, then replay
        for (int i = 0; i < 7; i++) send_pix(IW'((i / 5) * 16 + (i % 5)));
        rst = 1'b0;
        #1;
        chk("midreset_up_rdy", up_rdy, 0);
        chk("midreset_dn_val", dn_val, 0);
        chk("midreset_dn_last", dn_last, 0);
        chk("midreset_dn_data", dn_data, 0);
        q.delete();
        m_row = 0;
        m_col = 0;
        win_cnt = 0;
        tick();
        rst = 1'b1;
        tick();
        do_cfg(5, 4, 1'b1);
        lat_chk = 1'b1;
        send_frame(100, 1'b0);
        drain(6);

        // 6: random gaps, random back-pressure, random pixel data
        lat_chk = 1'b0;
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) send_frame(50, 1'b1);
        drain(18);

        // line length at the RAM depth and at the window width
        do_cfg(DEPTH, 3, 1'b1);
        send_frame(70, 1'b1);
        drain(DEPTH - 2);
        do_cfg(3, 4, 1'b1);
        send_frame(70, 1'b1);
        drain(2);
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
